// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: source/sink handshake bundle
// for the registered N-way source selector.
interface mux_sel_pipe_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] In_Data;
  logic [SEL_W-1:0]        In_Sel;
  logic                    Mode_RR;
  logic                    In_Valid;
  logic                    In_Ready;
  logic [WIDTH-1:0]        Out_Data;
  logic [SEL_W-1:0]        Out_Chan;
  logic                    Out_Valid;
  logic                    Out_Ready;
  logic                    Sel_Err;
  logic                    Err_Clr;

  modport master (
    output In_Data, In_Sel, Mode_RR, In_Valid,
    output Out_Ready, Err_Clr,
    input  In_Ready, Out_Data, Out_Chan,
    input  Out_Valid, Sel_Err
  );

  modport slave (
    input  In_Data, In_Sel, Mode_RR, In_Valid,
    input  Out_Ready, Err_Clr,
    output In_Ready, Out_Data, Out_Chan,
    output Out_Valid, Sel_Err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-way source selector,
// explicit or round-robin, with a 2-entry output FIFO.
module mux_sel_pipe #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4
) (
  input logic           Clk,
  input logic           Reset_n,
  mux_sel_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam logic [SEL_W:0] NUM_X =
    (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(NUM_IN-1);

  logic [1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [SEL_W-1:0] c0_q, c0_d;
  logic [SEL_W-1:0] c1_q, c1_d;
  logic [SEL_W-1:0] ch;
  logic [WIDTH-1:0] word;
  logic             bad;
  logic             push;
  logic             pop;

  assign ch   = bus.Mode_RR ? rr_q : bus.In_Sel;
  assign bad  = !bus.Mode_RR &&
                ({1'b0, bus.In_Sel} >= NUM_X);
  assign push = bus.In_Valid & bus.In_Ready;
  assign pop  = bus.Out_Valid & bus.Out_Ready;

  assign bus.In_Ready  = Reset_n & (cnt_q != 2'd2);
  assign bus.Out_Valid = (cnt_q != 2'd0);
  assign bus.Out_Data  = d0_q;
  assign bus.Out_Chan  = c0_q;
  assign bus.Sel_Err   = err_q;

  // Channel extract; an index with no channel gives zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (ch == SEL_W'(k))
        word = bus.In_Data[k*WIDTH +: WIDTH];
  end

  // Next state: FIFO slots, count, rr pointer, sticky error.
  always_comb begin
    cnt_d = cnt_q;
    rr_d  = rr_q;
    err_d = err_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    c0_d  = c0_q;
    c1_d  = c1_q;
    if (push && bus.Mode_RR)
      rr_d = (rr_q == LAST) ? '0 : rr_q + 1'b1;
    if (push && bad)
      err_d = 1'b1;
    else if (bus.Err_Clr)
      err_d = 1'b0;
    unique case (1'b1)
      (push && pop): begin
        d0_d = word;
        c0_d = bus.In_Sel;
        if (bus.Mode_RR) c0_d = rr_q;
      end
      (pop && !push): begin
        d0_d  = d1_q;
        c0_d  = c1_q;
        cnt_d = cnt_q - 2'd1;
      end
      (push && !pop): begin
        if (cnt_q == 2'd0) begin
          d0_d = word;
          c0_d = ch;
        end else begin
          d1_d = word;
          c1_d = ch;
        end
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      rr_q  <= '0;
      err_q <= 1'b0;
      d0_q  <= '0;
      d1_q  <= '0;
      c0_q  <= '0;
      c1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      err_q <= err_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
    end
  end
endmodule
